// File: rtl/stream_pkg.sv
// Shared definitions for the stream selector: FSM encoding and arbitration modes.
package stream_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin from ptr.
module rr_arbiter
    import stream_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1,
    parameter int MODE  = ARB_FIXED
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    // Search upward from the start index, wrapping; first requester wins.
    always_comb begin
        int start;
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        start = (MODE == ARB_RR) ? int'(ptr) : 0;
        for (int off = 0; off < N; off++) begin
            j = (start + off) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = SEL_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_sel_mux.sv
// N-channel registered stream selector with packet locking, forced select
// and fixed-priority or round-robin arbitration.
module stream_sel_mux
    import stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1,
    parameter int MODE  = ARB_FIXED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    input  logic               force_en,
    input  logic [SEL_W-1:0]   force_sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   lock_ch;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   g;
    logic [N-1:0]       arb_grant;
    logic [SEL_W-1:0]   arb_idx;
    logic               arb_any;
    logic               grant_valid;
    logic               accept;
    logic               take;
    logic               last_g;
    logic [WIDTH-1:0]   data_g;
    logic [N-1:0]       onehot_g;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W),
        .MODE  (MODE)
    ) u_arb (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Pick the candidate channel; an out-of-range force index matches nothing.
    always_comb begin
        grant_valid = 1'b0;
        last_g      = 1'b0;
        data_g      = '0;
        onehot_g    = '0;
        if (state == ST_LOCKED)
            g = lock_ch;
        else if (force_en)
            g = force_sel;
        else
            g = arb_idx;
        for (int i = 0; i < N; i++) begin
            if (g == SEL_W'(i)) begin
                grant_valid = in_valid[i];
                last_g      = in_last[i];
                data_g      = in_data[i*WIDTH +: WIDTH];
                onehot_g[i] = 1'b1;
            end
        end
        if (state == ST_IDLE && !force_en) begin
            grant_valid = arb_any;
            onehot_g    = arb_grant;
        end
        accept = !out_valid || out_ready;
        take   = accept && grant_valid;
    end

    // FSM state register; reset drops any packet lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
        end else begin
            state <= state_nxt;
            if (take && !last_g)
                lock_ch <= g;
        end
    end

    // Lock on a non-last beat, release on a last beat.
    always_comb begin
        state_nxt = state;
        if (take)
            state_nxt = last_g ? ST_IDLE : ST_LOCKED;
    end

    // Ready goes to the granted channel only when the output can take a beat.
    always_comb begin
        in_ready = take ? onehot_g : '0;
    end

    // Round-robin pointer moves past the winner at the end of each packet.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (MODE == ARB_RR && take && last_g)
            rr_ptr <= (g == SEL_W'(N-1)) ? '0 : g + 1'b1;
    end

    // Output register: load on accept, clear valid when drained, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= data_g;
            out_last  <= last_g;
            out_sel   <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/stream_sel_mux.md
Name: stream_sel_mux

Overview:
- Parametrised N-channel, WIDTH-bit registered stream selector; successor to the fixed 4:1 combinational selector in the CPU datapath.
- Adds valid/ready handshaking, one output register stage and fixed-priority or round-robin arbitration.
- Adds a forced-select override, equivalent to the old select-line behaviour, and packet locking via a last flag.
- Sits between multiple producers (e.g. writeback sources, bus masters) and a single consumer.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (≥1).
- SEL_W, max(1,$clog2(N)), select/index width (derived; not overridden).
- MODE, 0, arbitration: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_last  in  N  per-channel end-of-packet flag.
- in_ready  out  N  per-channel ready (one-hot or zero).
- force_en  in  1  override arbitration with force_sel.
- force_sel  in  SEL_W  forced channel index.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  output valid.
- out_last  out  1  registered last flag of the held beat.
- out_sel  out  SEL_W  index of the channel the held beat came from.
- out_ready  in  1  consumer ready.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset state: out_valid=0, out_data=0, out_last=0, out_sel=0, FSM=IDLE, rr pointer=0.
- Reset mid-packet discards the held beat and the lock.
- Transfers: a beat transfers on input i when in_valid[i] && in_ready[i]; on output when out_valid && out_ready.
- accept = !out_valid || out_ready (register empty, or draining this cycle).
- in_ready[g] = accept && grant_valid && (i==g); all other bits 0. Combinational from in_valid/FSM/pointer/force inputs.
- Producers must not make valid depend on ready.
- Latency: a beat accepted at edge k is presented on out_* after edge k.
- Full throughput: 1 beat/cycle when out_ready is held high.
- Hold: while out_valid && !out_ready, out_data, out_last and out_sel are stable and no input is accepted.
- FSM, IDLE (unlocked):
  - force_en=1: g = force_sel; grant_valid = in_valid[g] && force_sel<N. No fallback to other channels.
  - force_en=0, MODE=0: g = lowest i with in_valid[i].
  - force_en=0, MODE=1: g = first valid index searching from pointer upward, wrapping at N-1→0.
  - Accepted beat with in_last=0 → LOCKED on g. With in_last=1 → stay IDLE.
- FSM, LOCKED(g): only channel g is eligible; force_en and the other channels are ignored. An accepted beat with in_last=1 → IDLE.
- Round-robin pointer: updates only when a last beat is accepted, to (g+1) mod N. Forced grants also update it. Unchanged in MODE=0.
- Single-beat packets (in_last=1 on the first beat) never lock.
- N=1: channel 0 only; SEL_W=1; force_sel≠0 yields no grant.

Decomposition:
- Shared package stream_pkg: FSM state encoding (ST_IDLE, ST_LOCKED), MODE constants (ARB_FIXED=0, ARB_RR=1).
- One sub-module, rr_arbiter: N-bit request, pointer, MODE → one-hot grant + index. Purely combinational.
- Top level holds the FSM, pointer and output register.

Test Plan:
- Reset and single transfer: rst_n=0 for 2 cycles → all outputs 0. Then in_valid=4'b0100, in_data ch2=32'hDEADBEEF, in_last=1, out_ready=1 → in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=DEADBEEF, out_sel=2, out_last=1.
- Fixed priority: MODE=0, in_valid=4'b1010 held, out_ready=1, all last=1 → every cycle grants ch1; ch3 never gets in_ready.
- Round-robin: MODE=1, in_valid=4'b1111, last=1, out_ready=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles.
- Lock and backpressure: ch0 sends a 3-beat packet (last on beat 3) while ch1 is valid. out_ready=0 for 2 cycles after beat 1 → out_data held stable, no in_ready. Then out_ready=1 → beats 2,3 from ch0, then ch1.
- Force: force_en=1, force_sel=3, in_valid=4'b0001 → no grant, out_valid stays 0. Raise in_valid[3] with data 32'h12345678 → transfer from ch3, out_sel=3. Force asserted mid-lock on ch1 → ignored until ch1's last beat.
- Reset mid-packet: lock on ch2 after beat 1, pulse rst_n=0 one cycle → out_valid=0, FSM IDLE. Next arbitration grants the lowest valid channel (MODE=0) rather than ch2.
